// File: rtl/axi4_user_yanker_cmd_if.sv
// Bus bundle for the echo yanker: upstream (in_*) and downstream (out_*) AXI4 channels.
// The slave modport is the yanker's view; master is the surrounding environment.
interface axi4_user_yanker_cmd_if #(
    parameter int unsigned ID_BITS = 4
);
    logic               in_aw_valid, in_aw_ready, in_aw_bits_lock;
    logic [ID_BITS-1:0] in_aw_bits_id;
    logic [31:0]        in_aw_bits_addr;
    logic [7:0]         in_aw_bits_len;
    logic [2:0]         in_aw_bits_size, in_aw_bits_prot;
    logic [1:0]         in_aw_bits_burst;
    logic [3:0]         in_aw_bits_cache, in_aw_bits_qos;
    logic [3:0]         in_aw_bits_echo_tl_state_size, in_aw_bits_echo_tl_state_source;
    logic               out_aw_valid, out_aw_ready, out_aw_bits_lock;
    logic [ID_BITS-1:0] out_aw_bits_id;
    logic [31:0]        out_aw_bits_addr;
    logic [7:0]         out_aw_bits_len;
    logic [2:0]         out_aw_bits_size, out_aw_bits_prot;
    logic [1:0]         out_aw_bits_burst;
    logic [3:0]         out_aw_bits_cache, out_aw_bits_qos;

    logic               in_w_valid, in_w_ready, in_w_bits_last;
    logic [63:0]        in_w_bits_data;
    logic [7:0]         in_w_bits_strb;
    logic               out_w_valid, out_w_ready, out_w_bits_last;
    logic [63:0]        out_w_bits_data;
    logic [7:0]         out_w_bits_strb;

    logic               in_b_valid, in_b_ready;
    logic [ID_BITS-1:0] in_b_bits_id;
    logic [1:0]         in_b_bits_resp;
    logic [3:0]         in_b_bits_echo_tl_state_size, in_b_bits_echo_tl_state_source;
    logic               out_b_valid, out_b_ready;
    logic [ID_BITS-1:0] out_b_bits_id;
    logic [1:0]         out_b_bits_resp;

    logic               in_ar_valid, in_ar_ready, in_ar_bits_lock;
    logic [ID_BITS-1:0] in_ar_bits_id;
    logic [31:0]        in_ar_bits_addr;
    logic [7:0]         in_ar_bits_len;
    logic [2:0]         in_ar_bits_size, in_ar_bits_prot;
    logic [1:0]         in_ar_bits_burst;
    logic [3:0]         in_ar_bits_cache, in_ar_bits_qos;
    logic [3:0]         in_ar_bits_echo_tl_state_size, in_ar_bits_echo_tl_state_source;
    logic               out_ar_valid, out_ar_ready, out_ar_bits_lock;
    logic [ID_BITS-1:0] out_ar_bits_id;
    logic [31:0]        out_ar_bits_addr;
    logic [7:0]         out_ar_bits_len;
    logic [2:0]         out_ar_bits_size, out_ar_bits_prot;
    logic [1:0]         out_ar_bits_burst;
    logic [3:0]         out_ar_bits_cache, out_ar_bits_qos;

    logic               in_r_valid, in_r_ready, in_r_bits_last;
    logic [ID_BITS-1:0] in_r_bits_id;
    logic [63:0]        in_r_bits_data;
    logic [1:0]         in_r_bits_resp;
    logic [3:0]         in_r_bits_echo_tl_state_size, in_r_bits_echo_tl_state_source;
    logic               out_r_valid, out_r_ready, out_r_bits_last;
    logic [ID_BITS-1:0] out_r_bits_id;
    logic [63:0]        out_r_bits_data;
    logic [1:0]         out_r_bits_resp;

    modport slave (
        input  in_aw_valid, in_aw_bits_id, in_aw_bits_addr, in_aw_bits_len, in_aw_bits_size,
               in_aw_bits_burst, in_aw_bits_lock, in_aw_bits_cache, in_aw_bits_prot, in_aw_bits_qos,
               in_aw_bits_echo_tl_state_size, in_aw_bits_echo_tl_state_source, out_aw_ready,
        output in_aw_ready, out_aw_valid, out_aw_bits_id, out_aw_bits_addr, out_aw_bits_len,
               out_aw_bits_size, out_aw_bits_burst, out_aw_bits_lock, out_aw_bits_cache,
               out_aw_bits_prot, out_aw_bits_qos,
        input  in_w_valid, in_w_bits_data, in_w_bits_strb, in_w_bits_last, out_w_ready,
        output in_w_ready, out_w_valid, out_w_bits_data, out_w_bits_strb, out_w_bits_last,
        input  out_b_valid, out_b_bits_id, out_b_bits_resp, in_b_ready,
        output out_b_ready, in_b_valid, in_b_bits_id, in_b_bits_resp,
               in_b_bits_echo_tl_state_size, in_b_bits_echo_tl_state_source,
        input  in_ar_valid, in_ar_bits_id, in_ar_bits_addr, in_ar_bits_len, in_ar_bits_size,
               in_ar_bits_burst, in_ar_bits_lock, in_ar_bits_cache, in_ar_bits_prot, in_ar_bits_qos,
               in_ar_bits_echo_tl_state_size, in_ar_bits_echo_tl_state_source, out_ar_ready,
        output in_ar_ready, out_ar_valid, out_ar_bits_id, out_ar_bits_addr, out_ar_bits_len,
               out_ar_bits_size, out_ar_bits_burst, out_ar_bits_lock, out_ar_bits_cache,
               out_ar_bits_prot, out_ar_bits_qos,
        input  out_r_valid, out_r_bits_id, out_r_bits_data, out_r_bits_resp, out_r_bits_last, in_r_ready,
        output out_r_ready, in_r_valid, in_r_bits_id, in_r_bits_data, in_r_bits_resp, in_r_bits_last,
               in_r_bits_echo_tl_state_size, in_r_bits_echo_tl_state_source
    );

    modport master (
        output in_aw_valid, in_aw_bits_id, in_aw_bits_addr, in_aw_bits_len, in_aw_bits_size,
               in_aw_bits_burst, in_aw_bits_lock, in_aw_bits_cache, in_aw_bits_prot, in_aw_bits_qos,
               in_aw_bits_echo_tl_state_size, in_aw_bits_echo_tl_state_source, out_aw_ready,
        input  in_aw_ready, out_aw_valid, out_aw_bits_id, out_aw_bits_addr, out_aw_bits_len,
               out_aw_bits_size, out_aw_bits_burst, out_aw_bits_lock, out_aw_bits_cache,
               out_aw_bits_prot, out_aw_bits_qos,
        output in_w_valid, in_w_bits_data, in_w_bits_strb, in_w_bits_last, out_w_ready,
        input  in_w_ready, out_w_valid, out_w_bits_data, out_w_bits_strb, out_w_bits_last,
        output out_b_valid, out_b_bits_id, out_b_bits_resp, in_b_ready,
        input  out_b_ready, in_b_valid, in_b_bits_id, in_b_bits_resp,
               in_b_bits_echo_tl_state_size, in_b_bits_echo_tl_state_source,
        output in_ar_valid, in_ar_bits_id, in_ar_bits_addr, in_ar_bits_len, in_ar_bits_size,
               in_ar_bits_burst, in_ar_bits_lock, in_ar_bits_cache, in_ar_bits_prot, in_ar_bits_qos,
               in_ar_bits_echo_tl_state_size, in_ar_bits_echo_tl_state_source, out_ar_ready,
        input  in_ar_ready, out_ar_valid, out_ar_bits_id, out_ar_bits_addr, out_ar_bits_len,
               out_ar_bits_size, out_ar_bits_burst, out_ar_bits_lock, out_ar_bits_cache,
               out_ar_bits_prot, out_ar_bits_qos,
        output out_r_valid, out_r_bits_id, out_r_bits_data, out_r_bits_resp, out_r_bits_last, in_r_ready,
        input  out_r_ready, in_r_valid, in_r_bits_id, in_r_bits_data, in_r_bits_resp, in_r_bits_last,
               in_r_bits_echo_tl_state_size, in_r_bits_echo_tl_state_source
    );
endinterface

// File: rtl/axi4_user_yanker_cmd.sv
// Strips tl_state echo from AW/AR into per-ID FIFOs and re-attaches it to B/R by ID.
// axi4_user_yanker_cmd_q holds one direction's bank of per-ID echo queues.
module axi4_user_yanker_cmd_q #(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ECHO_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [ID_BITS-1:0]   push_id,
    input  logic [ECHO_BITS-1:0] push_echo,
    output logic                 full,
    input  logic                 pop_fire,
    input  logic                 pop_last,
    input  logic [ID_BITS-1:0]   pop_id,
    output logic [ECHO_BITS-1:0] head,
    output logic                 orphan,
    output logic                 all_empty
);
    localparam int unsigned NQ = 1 << ID_BITS;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [CW-1:0]        count [NQ];
    logic [PW-1:0]        wptr  [NQ];
    logic [PW-1:0]        rptr  [NQ];
    logic [ECHO_BITS-1:0] mem   [NQ*DEPTH];
    logic                 pop_empty, pop_take;
    logic [NQ-1:0]        push_sel, pop_sel;

    assign full      = (count[push_id] == CW'(DEPTH));
    assign pop_empty = (count[pop_id] == '0);
    assign head      = pop_empty ? '0 : mem[{pop_id, rptr[pop_id]}];
    assign orphan    = pop_fire & pop_empty;
    assign pop_take  = pop_fire & pop_last & ~pop_empty;

    always_comb begin
        push_sel = '0;
        pop_sel  = '0;
        if (push)     push_sel[push_id] = 1'b1;
        if (pop_take) pop_sel[pop_id]   = 1'b1;
    end

    // Same-cycle push and pop on one ID cancel in the count; the pop reads the old head.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NQ; i++) begin
                count[i] <= '0;
                wptr[i]  <= '0;
                rptr[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NQ; i++) begin
                if (push_sel[i]) wptr[i] <= wptr[i] + 1'b1;
                if (pop_sel[i])  rptr[i] <= rptr[i] + 1'b1;
                if (push_sel[i] != pop_sel[i])
                    count[i] <= push_sel[i] ? count[i] + 1'b1 : count[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[{push_id, wptr[push_id]}] <= push_echo;
    end

    always_comb begin
        all_empty = 1'b1;
        for (int unsigned i = 0; i < NQ; i++)
            if (count[i] != '0) all_empty = 1'b0;
    end
endmodule

module axi4_user_yanker_cmd #(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ECHO_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    axi4_user_yanker_cmd_if.slave bus,
    output logic                  idle,
    output logic                  err_orphan
);
    logic aw_full, ar_full, aw_push, ar_push, b_fire, r_fire;
    logic aw_orphan, ar_orphan, aw_empty, ar_empty;
    logic [ECHO_BITS-1:0] b_echo, r_echo;

    // Ready/valid gating looks only at registered counts, never at a same-cycle pop.
    assign bus.out_aw_valid      = bus.in_aw_valid & ~aw_full;
    assign bus.in_aw_ready       = bus.out_aw_ready & ~aw_full;
    assign aw_push               = bus.in_aw_valid & bus.out_aw_ready & ~aw_full;
    assign bus.out_aw_bits_id    = bus.in_aw_bits_id;
    assign bus.out_aw_bits_addr  = bus.in_aw_bits_addr;
    assign bus.out_aw_bits_len   = bus.in_aw_bits_len;
    assign bus.out_aw_bits_size  = bus.in_aw_bits_size;
    assign bus.out_aw_bits_burst = bus.in_aw_bits_burst;
    assign bus.out_aw_bits_lock  = bus.in_aw_bits_lock;
    assign bus.out_aw_bits_cache = bus.in_aw_bits_cache;
    assign bus.out_aw_bits_prot  = bus.in_aw_bits_prot;
    assign bus.out_aw_bits_qos   = bus.in_aw_bits_qos;

    assign bus.out_ar_valid      = bus.in_ar_valid & ~ar_full;
    assign bus.in_ar_ready       = bus.out_ar_ready & ~ar_full;
    assign ar_push               = bus.in_ar_valid & bus.out_ar_ready & ~ar_full;
    assign bus.out_ar_bits_id    = bus.in_ar_bits_id;
    assign bus.out_ar_bits_addr  = bus.in_ar_bits_addr;
    assign bus.out_ar_bits_len   = bus.in_ar_bits_len;
    assign bus.out_ar_bits_size  = bus.in_ar_bits_size;
    assign bus.out_ar_bits_burst = bus.in_ar_bits_burst;
    assign bus.out_ar_bits_lock  = bus.in_ar_bits_lock;
    assign bus.out_ar_bits_cache = bus.in_ar_bits_cache;
    assign bus.out_ar_bits_prot  = bus.in_ar_bits_prot;
    assign bus.out_ar_bits_qos   = bus.in_ar_bits_qos;

    assign bus.out_w_valid     = bus.in_w_valid;
    assign bus.in_w_ready      = bus.out_w_ready;
    assign bus.out_w_bits_data = bus.in_w_bits_data;
    assign bus.out_w_bits_strb = bus.in_w_bits_strb;
    assign bus.out_w_bits_last = bus.in_w_bits_last;

    assign bus.in_b_valid     = bus.out_b_valid;
    assign bus.out_b_ready    = bus.in_b_ready;
    assign bus.in_b_bits_id   = bus.out_b_bits_id;
    assign bus.in_b_bits_resp = bus.out_b_bits_resp;
    assign {bus.in_b_bits_echo_tl_state_size, bus.in_b_bits_echo_tl_state_source} = b_echo;
    assign b_fire = bus.out_b_valid & bus.in_b_ready;

    assign bus.in_r_valid     = bus.out_r_valid;
    assign bus.out_r_ready    = bus.in_r_ready;
    assign bus.in_r_bits_id   = bus.out_r_bits_id;
    assign bus.in_r_bits_data = bus.out_r_bits_data;
    assign bus.in_r_bits_resp = bus.out_r_bits_resp;
    assign bus.in_r_bits_last = bus.out_r_bits_last;
    assign {bus.in_r_bits_echo_tl_state_size, bus.in_r_bits_echo_tl_state_source} = r_echo;
    assign r_fire = bus.out_r_valid & bus.in_r_ready;

    axi4_user_yanker_cmd_q #(.ID_BITS(ID_BITS), .DEPTH(DEPTH), .ECHO_BITS(ECHO_BITS)) u_aw_q (
        .clock(clock), .reset(reset), .push(aw_push), .push_id(bus.in_aw_bits_id),
        .push_echo({bus.in_aw_bits_echo_tl_state_size, bus.in_aw_bits_echo_tl_state_source}),
        .full(aw_full), .pop_fire(b_fire), .pop_last(1'b1), .pop_id(bus.out_b_bits_id),
        .head(b_echo), .orphan(aw_orphan), .all_empty(aw_empty)
    );

    axi4_user_yanker_cmd_q #(.ID_BITS(ID_BITS), .DEPTH(DEPTH), .ECHO_BITS(ECHO_BITS)) u_ar_q (
        .clock(clock), .reset(reset), .push(ar_push), .push_id(bus.in_ar_bits_id),
        .push_echo({bus.in_ar_bits_echo_tl_state_size, bus.in_ar_bits_echo_tl_state_source}),
        .full(ar_full), .pop_fire(r_fire), .pop_last(bus.out_r_bits_last), .pop_id(bus.out_r_bits_id),
        .head(r_echo), .orphan(ar_orphan), .all_empty(ar_empty)
    );

    assign idle = aw_empty & ar_empty;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       err_orphan <= 1'b0;
        else if (aw_orphan | ar_orphan)   err_orphan <= 1'b1;
    end
endmodule

// File: tb/tb_axi4_user_yanker_cmd.sv
// Directed and randomized bench for axi4_user_yanker_cmd against per-ID queue model.
module tb_axi4_user_yanker_cmd;
    localparam int unsigned ID_BITS = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned NQ      = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic idle, err_orphan;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [7:0] awq [NQ][$];
    logic [7:0] arq [NQ][$];
    bit orphan_m = 1'b0;
    bit aw_rdy = 1'b1;
    bit ar_rdy = 1'b1;

    axi4_user_yanker_cmd_if #(.ID_BITS(ID_BITS)) bus ();

    axi4_user_yanker_cmd #(.ID_BITS(ID_BITS), .DEPTH(DEPTH), .ECHO_BITS(8)) dut (
        .clock(clock), .reset(reset), .bus(bus), .idle(idle), .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_idle();
        for (int i = 0; i < NQ; i++)
            if (awq[i].size() != 0 || arq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int pick_nonempty(input bit is_aw);
        int start;
        int idx;
        start = $urandom_range(0, NQ - 1);
        for (int k = 0; k < NQ; k++) begin
            idx = (start + k) % NQ;
            if (is_aw && awq[idx].size() != 0) return idx;
            if (!is_aw && arq[idx].size() != 0) return idx;
        end
        return -1;
    endfunction

    task automatic clear_valids();
        bus.in_aw_valid = 1'b0;
        bus.in_ar_valid = 1'b0;
        bus.out_b_valid = 1'b0;
        bus.out_r_valid = 1'b0;
        bus.in_w_valid  = 1'b0;
    endtask

    task automatic step(input bit awv, input logic [3:0] awid, input logic [7:0] awe,
                        input bit bv, input logic [3:0] bid,
                        input bit arv, input logic [3:0] arid, input logic [7:0] are,
                        input bit rv, input logic [3:0] rid, input bit rlast);
        logic [31:0] a_addr, r_addr;
        logic [63:0] wd, rd;
        logic [7:0]  exp_echo;
        bit aw_full, ar_full;
        a_addr = $urandom;
        r_addr = $urandom;
        wd = {$urandom, $urandom};
        rd = {$urandom, $urandom};
        bus.in_aw_valid = awv;
        bus.in_aw_bits_id = awid;
        bus.in_aw_bits_addr = a_addr;
        bus.in_aw_bits_len = 8'($urandom);
        {bus.in_aw_bits_echo_tl_state_size, bus.in_aw_bits_echo_tl_state_source} = awe;
        bus.out_aw_ready = aw_rdy;
        bus.in_ar_valid = arv;
        bus.in_ar_bits_id = arid;
        bus.in_ar_bits_addr = r_addr;
        {bus.in_ar_bits_echo_tl_state_size, bus.in_ar_bits_echo_tl_state_source} = are;
        bus.out_ar_ready = ar_rdy;
        bus.in_w_valid = 1'b1;
        bus.in_w_bits_data = wd;
        bus.out_w_ready = 1'b1;
        bus.out_b_valid = bv;
        bus.out_b_bits_id = bid;
        bus.out_b_bits_resp = 2'($urandom);
        bus.in_b_ready = 1'b1;
        bus.out_r_valid = rv;
        bus.out_r_bits_id = rid;
        bus.out_r_bits_data = rd;
        bus.out_r_bits_last = rlast;
        bus.in_r_ready = 1'b1;
        #1;
        aw_full = (awq[awid].size() == DEPTH);
        ar_full = (arq[arid].size() == DEPTH);
        chk("aw_valid", bus.out_aw_valid, awv && !aw_full);
        chk("aw_ready", bus.in_aw_ready, aw_rdy && !aw_full);
        chk("ar_valid", bus.out_ar_valid, arv && !ar_full);
        chk("ar_ready", bus.in_ar_ready, ar_rdy && !ar_full);
        chk("w_data", bus.out_w_bits_data, wd);
        if (awv) chk("aw_addr", bus.out_aw_bits_addr, a_addr);
        if (arv) chk("ar_addr", bus.out_ar_bits_addr, r_addr);
        chk("b_valid", bus.in_b_valid, bv);
        if (bv) begin
            exp_echo = (awq[bid].size() != 0) ? awq[bid][0] : 8'h00;
            chk("b_echo", {bus.in_b_bits_echo_tl_state_size, bus.in_b_bits_echo_tl_state_source}, exp_echo);
            chk("b_id", bus.in_b_bits_id, bid);
        end
        chk("r_valid", bus.in_r_valid, rv);
        if (rv) begin
            exp_echo = (arq[rid].size() != 0) ? arq[rid][0] : 8'h00;
            chk("r_echo", {bus.in_r_bits_echo_tl_state_size, bus.in_r_bits_echo_tl_state_source}, exp_echo);
            chk("r_data", bus.in_r_bits_data, rd);
            chk("r_last", bus.in_r_bits_last, rlast);
        end
        @(posedge clock);
        if (bv) begin
            if (awq[bid].size() == 0) orphan_m = 1'b1;
            else void'(awq[bid].pop_front());
        end
        if (rv) begin
            if (arq[rid].size() == 0) orphan_m = 1'b1;
            else if (rlast) void'(arq[rid].pop_front());
        end
        if (awv && aw_rdy && !aw_full) awq[awid].push_back(awe);
        if (arv && ar_rdy && !ar_full) arq[arid].push_back(are);
        #1;
        clear_valids();
        chk("idle", idle, model_idle());
        chk("err_orphan", err_orphan, orphan_m);
    endtask

    task automatic aw(input logic [3:0] id, input logic [7:0] e);
        step(1'b1, id, e, 1'b0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    endtask
    task automatic b(input logic [3:0] id);
        step(1'b0, 4'd0, 8'd0, 1'b1, id, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
    endtask
    task automatic ar(input logic [3:0] id, input logic [7:0] e);
        step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, id, e, 1'b0, 4'd0, 1'b0);
    endtask
    task automatic r(input logic [3:0] id, input bit last);
        step(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 4'd0, 8'd0, 1'b1, id, last);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            awq[i].delete();
            arq[i].delete();
        end
        orphan_m = 1'b0;
        bus.out_aw_ready = 1'b1;
        bus.in_aw_bits_id = 4'd2;
        bus.in_aw_valid = 1'b1;
        #1;
        chk("rst_aw_valid_hi", bus.out_aw_valid, 1'b1);
        chk("rst_aw_ready", bus.in_aw_ready, 1'b1);
        bus.in_aw_valid = 1'b0;
        #1;
        chk("rst_aw_valid_lo", bus.out_aw_valid, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_err_orphan", err_orphan, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit awv, bv, arv, rv, rl;
        logic [3:0] awid, arid, bid, rid;
        int pid;
        clear_valids();
        bus.out_aw_ready = 1'b1;
        bus.out_ar_ready = 1'b1;
        bus.in_b_ready   = 1'b1;
        bus.in_r_ready   = 1'b1;
        bus.out_w_ready  = 1'b1;
        bus.in_w_bits_strb = '0;
        bus.in_w_bits_last = 1'b0;
        bus.in_aw_bits_size = '0; bus.in_aw_bits_burst = '0; bus.in_aw_bits_lock = 1'b0;
        bus.in_aw_bits_cache = '0; bus.in_aw_bits_prot = '0; bus.in_aw_bits_qos = '0;
        bus.in_ar_bits_len = '0; bus.in_ar_bits_size = '0; bus.in_ar_bits_burst = '0;
        bus.in_ar_bits_lock = 1'b0; bus.in_ar_bits_cache = '0; bus.in_ar_bits_prot = '0;
        bus.in_ar_bits_qos = '0; bus.out_r_bits_resp = '0;
        #2;
        do_reset();

        aw(4'd3, 8'h59);
        b(4'd3);

        for (int i = 0; i < 4; i++) aw(4'd2, 8'(8'h40 + i));
        aw(4'd2, 8'hEE);
        aw(4'd7, 8'h77);
        step(1'b1, 4'd2, 8'hDD, 1'b1, 4'd2, 1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
        aw(4'd2, 8'h4C);
        aw_rdy = 1'b0;
        aw(4'd9, 8'h99);
        aw_rdy = 1'b1;
        for (int i = 0; i < 4; i++) b(4'd2);
        b(4'd7);

        ar(4'd1, 8'h3A);
        for (int i = 0; i < 4; i++) r(4'd1, i == 3);

        aw(4'd0, 8'h11);
        aw(4'd4, 8'h22);
        b(4'd4);
        b(4'd0);

        for (int n = 0; n < 100; n++) begin
            awv = 1'($urandom_range(0, 1));
            arv = 1'($urandom_range(0, 1));
            awid = 4'($urandom_range(0, 7));
            arid = 4'($urandom_range(0, 7));
            aw_rdy = ($urandom_range(0, 3) != 0);
            ar_rdy = ($urandom_range(0, 3) != 0);
            pid = pick_nonempty(1'b1);
            bv = (pid >= 0) && ($urandom_range(0, 2) != 0);
            bid = 4'(pid);
            pid = pick_nonempty(1'b0);
            rv = (pid >= 0) && ($urandom_range(0, 2) != 0);
            rid = 4'(pid);
            rl = 1'($urandom_range(0, 1));
            step(awv, awid, 8'($urandom), bv, bid, arv, arid, 8'($urandom), rv, rid, rl);
        end
        aw_rdy = 1'b1;
        ar_rdy = 1'b1;

        do_reset();
        b(4'd6);
        b(4'd6);
        do_reset();

        aw(4'd5, 8'h5A);
        ar(4'd9, 8'h9C);
        do_reset();
        r(4'd9, 1'b1);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
